// File: rtl/edge_blob_statistics_pkg.sv
// Shared constants, FSM encoding and result-word packing for the edge blob statistics stage.
// Defaults describe the 320x240 frame with garbage rows trimmed at top and bottom.
package edge_blob_statistics_pkg;

  localparam int          IMG_WIDTH       = 320;
  localparam int          IMG_HEIGHT      = 240;
  localparam int          IMG_SKIP_LINES  = 7;
  localparam int          IMG_RESULT_ADDR = 76800;
  localparam logic [31:0] IMG_FG_VALUE    = 32'd1;
  localparam logic [15:0] EMPTY_SENTINEL  = 16'hFFFF;

  localparam logic [1:0] RES_CNT = 2'd0;
  localparam logic [1:0] RES_MIN = 2'd1;
  localparam logic [1:0] RES_MAX = 2'd2;
  localparam logic [1:0] RES_CEN = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_SCAN   = 4'd2,
    S_DRAIN  = 4'd3,
    S_DIV_XS = 4'd4,
    S_DIV_XW = 4'd5,
    S_DIV_YS = 4'd6,
    S_DIV_YW = 4'd7,
    S_WRITE  = 4'd8,
    S_DONE   = 4'd9
  } blob_state_e;

  function automatic logic [31:0] pack_pair(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/edge_blob_statistics_divider.sv
// Restoring serial divider, one quotient bit per cycle (32 cycles), truncating.
// Shares the stage's synchronous active-low reset and pause-freeze behaviour.
module serial_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [16:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);

  logic [31:0] quot_q, quot_d;
  logic [16:0] rem_q, rem_d, dsr_q, dsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [17:0] trial_s;

  // One restoring step per busy cycle; done pulses once after the 32nd step.
  always_comb begin
    quot_d  = quot_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trial_s = {rem_q, quot_q[31]};
    if (clr) begin
      busy_d = 1'b0;
    end else if (start && !busy_q) begin
      quot_d = dividend;
      rem_d  = 17'd0;
      dsr_d  = divisor;
      cnt_d  = 5'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder stays below the divisor, so the 17-bit difference is exact.
      if (trial_s >= {1'b0, dsr_q}) begin
        rem_d  = trial_s[16:0] - dsr_q;
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = trial_s[16:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // State register: reset wins over pause, pause freezes everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quot_q <= 32'd0;
      rem_q  <= 17'd0;
      dsr_q  <= 17'd0;
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (!pause) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quot_q[15:0];

endmodule

// File: rtl/edge_blob_statistics.sv
// Scans the filled binary edge map in frame RAM, accumulates count, bounding box and
// centroid of foreground pixels over the valid rows, and writes four result words back.
module edge_blob_statistics
  import edge_blob_statistics_pkg::*;
#(
  parameter int          WIDTH       = IMG_WIDTH,
  parameter int          HEIGHT      = IMG_HEIGHT,
  parameter int          SKIP_LINES  = IMG_SKIP_LINES,
  parameter logic [31:0] FG_VALUE    = IMG_FG_VALUE,
  parameter int          RESULT_ADDR = IMG_RESULT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause,
  input  logic        enable_blob_stats,
  input  logic [31:0] data_read,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic        blob_stats_done
);

  localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
  localparam logic [15:0] Y_FIRST   = 16'(SKIP_LINES);
  localparam logic [15:0] Y_LAST    = 16'(HEIGHT - SKIP_LINES - 1);
  localparam logic [17:0] SCAN_BASE = 18'(SKIP_LINES * WIDTH);
  localparam logic [17:0] RES_BASE  = 18'(RESULT_ADDR);

  if (RESULT_ADDR + 3 > 262143) begin : g_result_addr_illegal
    $error("RESULT_ADDR+3 exceeds the 18-bit address space");
  end

  blob_state_e state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [17:0] address_q, address_d;
  logic        wren_q, wren_d, done_q, done_d;
  logic [31:0] data_write_q, data_write_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [15:0] cx_q, cx_d, cy_q, cy_d;
  logic        smp_vld_q, smp_vld_d, smp_hit_q, smp_hit_d;
  logic [15:0] smp_x_q, smp_x_d, smp_y_q, smp_y_d;
  logic [16:0] count_q, count_d;
  logic [31:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [15:0] min_x_q, min_x_d, min_y_q, min_y_d, max_x_q, max_x_d, max_y_q, max_y_d;

  logic        div_start_s, div_busy_s, div_done_s, div_clr_s;
  logic [31:0] div_dividend_s;
  logic [15:0] div_quot_s;

  assign div_clr_s = (state_q == S_IDLE);

  serial_divider u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .pause    (pause),
    .clr      (div_clr_s),
    .start    (div_start_s),
    .dividend (div_dividend_s),
    .divisor  (count_q),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quot_s)
  );

  // FSM next state, scan address generation, sample capture and write mux.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    address_d      = 18'd0;
    wren_d         = 1'b0;
    data_write_d   = 32'd0;
    done_d         = 1'b0;
    wr_idx_d       = wr_idx_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    div_start_s    = 1'b0;
    div_dividend_s = sum_x_q;
    smp_vld_d      = 1'b0;
    smp_hit_d      = (data_read == FG_VALUE);
    smp_x_d        = x_q;
    smp_y_d        = y_q;
    if (!enable_blob_stats) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CLEAR;
        S_CLEAR: begin
          address_d = SCAN_BASE;
          x_d       = 16'd0;
          y_d       = Y_FIRST;
          wr_idx_d  = 2'd0;
          state_d   = S_SCAN;
        end
        S_SCAN: begin
          // data_read belongs to address_q, i.e. pixel (x_q, y_q).
          smp_vld_d = 1'b1;
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              state_d = S_DRAIN;
            end else begin
              x_d       = 16'd0;
              y_d       = y_q + 16'd1;
              address_d = address_q + 18'd1;
            end
          end else begin
            x_d       = x_q + 16'd1;
            address_d = address_q + 18'd1;
          end
        end
        S_DRAIN: state_d = S_DIV_XS;
        S_DIV_XS: begin
          if (count_q == 17'd0) begin
            cx_d     = EMPTY_SENTINEL;
            cy_d     = EMPTY_SENTINEL;
            wr_idx_d = 2'd0;
            state_d  = S_WRITE;
          end else if (!div_busy_s) begin
            div_start_s = 1'b1;
            state_d     = S_DIV_XW;
          end else begin
            state_d = S_DIV_XS;
          end
        end
        S_DIV_XW: begin
          if (div_done_s) begin
            cx_d    = div_quot_s;
            state_d = S_DIV_YS;
          end else begin
            state_d = S_DIV_XW;
          end
        end
        S_DIV_YS: begin
          div_dividend_s = sum_y_q;
          if (!div_busy_s) begin
            div_start_s = 1'b1;
            state_d     = S_DIV_YW;
          end else begin
            state_d = S_DIV_YS;
          end
        end
        S_DIV_YW: begin
          if (div_done_s) begin
            cy_d     = div_quot_s;
            wr_idx_d = 2'd0;
            state_d  = S_WRITE;
          end else begin
            state_d = S_DIV_YW;
          end
        end
        S_WRITE: begin
          wren_d    = 1'b1;
          address_d = RES_BASE + {16'd0, wr_idx_q};
          case (wr_idx_q)
            RES_CNT: data_write_d = {15'd0, count_q};
            RES_MIN: data_write_d = pack_pair(min_x_q, min_y_q);
            RES_MAX: data_write_d = pack_pair(max_x_q, max_y_q);
            RES_CEN: data_write_d = pack_pair(cx_q, cy_q);
            default: data_write_d = 32'd0;
          endcase
          wr_idx_d = wr_idx_q + 2'd1;
          if (wr_idx_q == RES_CEN) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_DONE:  done_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Accumulators: cleared on CLEAR, updated one cycle after a sample hits.
  always_comb begin
    count_d = count_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    min_x_d = min_x_q;
    min_y_d = min_y_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    if (state_q == S_CLEAR) begin
      count_d = 17'd0;
      sum_x_d = 32'd0;
      sum_y_d = 32'd0;
      min_x_d = EMPTY_SENTINEL;
      min_y_d = EMPTY_SENTINEL;
      max_x_d = 16'd0;
      max_y_d = 16'd0;
    end else if (smp_vld_q && smp_hit_q) begin
      count_d = count_q + 17'd1;
      sum_x_d = sum_x_q + {16'd0, smp_x_q};
      sum_y_d = sum_y_q + {16'd0, smp_y_q};
      if (smp_x_q < min_x_q) min_x_d = smp_x_q; else min_x_d = min_x_q;
      if (smp_y_q < min_y_q) min_y_d = smp_y_q; else min_y_d = min_y_q;
      if (smp_x_q > max_x_q) max_x_d = smp_x_q; else max_x_d = max_x_q;
      if (smp_y_q > max_y_q) max_y_d = smp_y_q; else max_y_d = max_y_q;
    end else begin
      count_d = count_q;
    end
  end

  // All state: synchronous reset has priority, pause holds every flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      address_q    <= 18'd0;
      wren_q       <= 1'b0;
      data_write_q <= 32'd0;
      done_q       <= 1'b0;
      wr_idx_q     <= 2'd0;
      cx_q         <= 16'd0;
      cy_q         <= 16'd0;
      smp_vld_q    <= 1'b0;
      smp_hit_q    <= 1'b0;
      smp_x_q      <= 16'd0;
      smp_y_q      <= 16'd0;
      count_q      <= 17'd0;
      sum_x_q      <= 32'd0;
      sum_y_q      <= 32'd0;
      min_x_q      <= 16'd0;
      min_y_q      <= 16'd0;
      max_x_q      <= 16'd0;
      max_y_q      <= 16'd0;
    end else if (!pause) begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      address_q    <= address_d;
      wren_q       <= wren_d;
      data_write_q <= data_write_d;
      done_q       <= done_d;
      wr_idx_q     <= wr_idx_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      smp_vld_q    <= smp_vld_d;
      smp_hit_q    <= smp_hit_d;
      smp_x_q      <= smp_x_d;
      smp_y_q      <= smp_y_d;
      count_q      <= count_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      min_x_q      <= min_x_d;
      min_y_q      <= min_y_d;
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
    end
  end

  assign wren            = wren_q;
  assign data_write      = data_write_q;
  assign address         = address_q;
  assign blob_stats_done = done_q;

endmodule

// File: tb/tb_edge_blob_statistics.sv
// Scoreboard bench for edge_blob_statistics on an 8x6 frame (1 skipped row top and bottom).
// Expected result writes are queued per frame; a monitor pops them as the DUT writes.
module tb_edge_blob_statistics;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int SK = 1;
  localparam int RA = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pause = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data_read, data_write;
  logic        wren, done;
  logic [17:0] address;
  logic [31:0] mem [0:127];
  bit          pause_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  edge_blob_statistics #(
    .WIDTH(W), .HEIGHT(H), .SKIP_LINES(SK), .FG_VALUE(32'd1), .RESULT_ADDR(RA)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pause             (pause),
    .enable_blob_stats (enable),
    .data_read         (data_read),
    .wren              (wren),
    .data_write        (data_write),
    .address           (address),
    .blob_stats_done   (done)
  );

  always #5 clk = ~clk;

  assign data_read = (address < 18'd128) ? mem[address[6:0]] : 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
  endtask

  task automatic set_fg(input int x, input int y);
    mem[y * W + x] = 32'd1;
  endtask

  // Random stall generator, about 30% duty while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pause = pause_en ? ($urandom_range(0, 9) < 3) : 1'b0;
    end
  end

  // Write monitor: a write is transferred at a posedge with wren=1 and pause=0.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n && wren && !pause) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", address, data_write);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {14'd0, address}, {14'd0, e.addr});
          check("wr_data", data_write, e.data);
        end
      end
    end
  end

  task automatic run_frame(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input bit use_pause);
    logic got;
    exp_q.push_back({18'(RA + 0), w0});
    exp_q.push_back({18'(RA + 1), w1});
    exp_q.push_back({18'(RA + 2), w2});
    exp_q.push_back({18'(RA + 3), w3});
    pause_en = use_pause;
    enable   = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    check({name, "_done"}, {31'd0, got}, 32'd1);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    pause_en = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, {31'd0, done}, 32'd1);
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 check({name, "_done_drop"}, {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wren"}, {31'd0, wren}, 32'd0);
    check({name, "_addr"}, {14'd0, address}, 32'd0);
    check({name, "_wdata"}, data_write, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    clear_map();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("zero", 32'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    clear_map();
    set_fg(3, 2);
    run_frame("single", 32'd1, 32'h0003_0002, 32'h0003_0002, 32'h0003_0002, 1'b0);

    clear_map();
    set_fg(0, 1);
    set_fg(7, 4);
    set_fg(7, 1);
    run_frame("three", 32'd3, 32'h0000_0001, 32'h0007_0004, 32'h0004_0002, 1'b0);

    clear_map();
    for (int x = 0; x < W; x++) begin
      set_fg(x, 0);
      set_fg(x, H - 1);
    end
    run_frame("skip_rows", 32'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    clear_map();
    set_fg(0, 1);
    set_fg(7, 4);
    set_fg(7, 1);
    run_frame("three_pause", 32'd3, 32'h0000_0001, 32'h0007_0004, 32'h0004_0002, 1'b1);

    // Whole frame set: 32 valid pixels, sum_x=112 -> 3, sum_y=80 -> 2.
    for (int i = 0; i < W * H; i++) mem[i] = 32'd1;
    run_frame("full", 32'd32, 32'h0000_0001, 32'h0007_0004, 32'h0003_0002, 1'b1);

    clear_map();
    set_fg(3, 2);
    enable = 1'b1;
    repeat (12) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 check("en_abort_done", {31'd0, done}, 32'd0);
    check("en_abort_wren", {31'd0, wren}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    run_frame("after_en_abort", 32'd1, 32'h0003_0002, 32'h0003_0002, 32'h0003_0002, 1'b0);

    enable = 1'b1;
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_abort");
    reset_n = 1'b1;
    run_frame("after_rst_abort", 32'd1, 32'h0003_0002, 32'h0003_0002, 32'h0003_0002, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
